// File: rtl/apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// apb_regfile_slave
//   APB4 completer in front of a DEPTH x DATA_WIDTH register file. It supports
//   byte strobes and programmable wait states. It returns an error response for
//   misaligned, out-of-range and unprivileged accesses, and it keeps a
//   saturating count of errored transfers.
//
// Handshake:
//   A transfer starts with a setup cycle (psel=1, penable=0). The slave captures
//   the whole request on that edge and evaluates the error flag at that point.
//   During the access phase (psel=1, penable=1), pready rises after
//   WAIT_STATES extra cycles. pslverr is valid only while pready=1. The request
//   completes on the rising edge where pready=1. If psel drops before that edge,
//   the transfer is abandoned with no side effects.
//
// Ports:
//   pclk, preset        clock, synchronous active-high reset
//   psel, penable       APB select / access strobe
//   pwrite              1 = write, 0 = read
//   paddr [ADDR_WIDTH]  byte address
//   pprot [3]           protection, bit 0 = privileged
//   pwdata, pstrb       write data and byte strobes
//   prdata              read data (0 outside a successful read)
//   pready, pslverr     completion and error response
//   err_cnt [8]         saturating count of errored transfers
//   o_dbg_state         current FSM state (0 = IDLE, 1 = ACCESS)
// ---------------------------------------------------------------------------
module apb_regfile_slave #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 32,
   parameter int DEPTH       = 32,
   parameter int WAIT_STATES = 0,
   parameter int PROT_CHECK  = 1,
   parameter int PRIV_BASE   = 16
) (
   input  logic                    pclk,
   input  logic                    preset,
   input  logic                    psel,
   input  logic                    penable,
   input  logic                    pwrite,
   input  logic [ADDR_WIDTH-1:0]   paddr,
   input  logic [2:0]              pprot,
   input  logic [DATA_WIDTH-1:0]   pwdata,
   input  logic [DATA_WIDTH/8-1:0] pstrb,
   output logic [DATA_WIDTH-1:0]   prdata,
   output logic                    pready,
   output logic                    pslverr,
   output logic [7:0]              err_cnt,
   output logic [0:0]              o_dbg_state
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int ALIGN  = $clog2(NBYTES);
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN) - 1);

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_ACCESS = 1'b1;

   // Request state captured in the setup cycle
   logic [0:0]            r_state;
   logic [3:0]            r_cnt;
   logic                  r_err;
   logic                  r_write;
   logic [IDX_W-1:0]      r_idx;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [NBYTES-1:0]     r_strb;
   logic [DATA_WIDTH-1:0] r_prdata;
   logic [7:0]            r_err_cnt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Decode of the live bus address. It is used only in the setup cycle.
   logic [ADDR_WIDTH-1:0] w_idx_full;
   logic [IDX_W-1:0]      w_idx;
   logic                  w_misaligned;
   logic                  w_out_of_range;
   logic                  w_priv_violation;
   logic                  w_err;
   logic                  w_pready;
   logic                  w_setup;
   logic                  w_unused;

   assign w_idx_full       = paddr >> ALIGN;
   assign w_idx            = w_idx_full[IDX_W-1:0];
   assign w_misaligned     = |(paddr & ALIGN_MASK);
   assign w_out_of_range   = (w_idx_full >= ADDR_WIDTH'(DEPTH));
   assign w_priv_violation = (PROT_CHECK != 0) && !pprot[0] &&
                             (w_idx_full >= ADDR_WIDTH'(PRIV_BASE));
   assign w_err            = w_misaligned || w_out_of_range || w_priv_violation;
   assign w_setup          = psel && !penable;

   // Only the privileged bit of pprot has meaning here.
   assign w_unused = ^pprot[2:1];

   // The completion strobe is combinational from registered state and the live
   // strobes, so a zero-wait transfer finishes in its first access cycle.
   always_comb begin
      w_pready = (r_state == S_ACCESS) && (r_cnt == 4'd0) && psel && penable;
   end

   assign pready      = w_pready;
   assign pslverr     = w_pready && r_err;
   assign prdata      = r_prdata;
   assign err_cnt     = r_err_cnt;
   assign o_dbg_state = r_state;

   always_ff @(posedge pclk) begin
      if (preset) begin
         r_state   <= S_IDLE;
         r_cnt     <= 4'd0;
         r_err     <= 1'b0;
         r_write   <= 1'b0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_strb    <= '0;
         r_prdata  <= '0;
         r_err_cnt <= 8'd0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_setup) begin
                  r_state <= S_ACCESS;
                  r_cnt   <= 4'(WAIT_STATES);
                  r_err   <= w_err;
                  r_write <= pwrite;
                  r_idx   <= w_idx;
                  r_wdata <= pwdata;
                  r_strb  <= pstrb;
                  // Read data is fetched here so that it is stable for the
                  // whole access phase. An errored read returns zero.
                  if (!pwrite && !w_err) begin
                     r_prdata <= r_mem[w_idx];
                  end else begin
                     r_prdata <= '0;
                  end
               end
            end
            S_ACCESS: begin
               if (!psel) begin
                  // The master abandoned the transfer, so it leaves no side effects.
                  r_state  <= S_IDLE;
                  r_prdata <= '0;
               end else if (penable) begin
                  if (r_cnt != 4'd0) begin
                     r_cnt <= r_cnt - 4'd1;
                  end
                  if (w_pready) begin
                     r_state  <= S_IDLE;
                     r_prdata <= '0;
                     if (r_err) begin
                        if (r_err_cnt != 8'hFF) begin
                           r_err_cnt <= r_err_cnt + 8'd1;
                        end
                     end else if (r_write) begin
                        for (int b = 0; b < NBYTES; b++) begin
                           if (r_strb[b]) begin
                              r_mem[r_idx][b*8 +: 8] <= r_wdata[b*8 +: 8];
                           end
                        end
                     end
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_regfile_slave
//   Directed bench for two instances: u_dut0 (zero wait states) and u_dut3
//   (three wait states). The instances share every bus input except psel, so
//   only the selected instance sees a transfer.
// ---------------------------------------------------------------------------
module tb_apb_regfile_slave;

   logic        pclk = 1'b0;
   logic        preset;
   logic        psel0, psel3;
   logic        penable;
   logic        pwrite;
   logic [31:0] paddr;
   logic [2:0]  pprot;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;

   logic [31:0] prdata0, prdata3;
   logic        pready0, pready3;
   logic        pslverr0, pslverr3;
   logic [7:0]  err_cnt0, err_cnt3;
   logic [0:0]  dbg0, dbg3;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 pclk = ~pclk;

   apb_regfile_slave #(.WAIT_STATES(0)) u_dut0 (
      .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
      .pstrb(pstrb), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
      .err_cnt(err_cnt0), .o_dbg_state(dbg0)
   );

   apb_regfile_slave #(.WAIT_STATES(3)) u_dut3 (
      .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pprot(pprot), .pwdata(pwdata),
      .pstrb(pstrb), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
      .err_cnt(err_cnt3), .o_dbg_state(dbg3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Runs one complete transfer. The task is entered #1 after a clock edge and
   // returns #1 after the completion edge. acc_cycles reports how many access
   // cycles passed until pready was seen, or -1 if the wait bound expired.
   task automatic apb_xfer(input int which, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] strb,
                           input logic [2:0] prot, output logic [31:0] rdata,
                           output logic slverr, output int acc_cycles);
      int n;
      logic rdy;
      paddr = addr; pwrite = wr; pwdata = wdata; pstrb = strb; pprot = prot;
      penable = 1'b0;
      if (which == 0) psel0 = 1'b1; else psel3 = 1'b1;
      @(posedge pclk); #1;
      penable = 1'b1;
      #1;
      n = 1;
      rdy = (which == 0) ? pready0 : pready3;
      while (!rdy && n < 40) begin
         @(posedge pclk); #2;
         n++;
         rdy = (which == 0) ? pready0 : pready3;
      end
      rdata  = (which == 0) ? prdata0 : prdata3;
      slverr = (which == 0) ? pslverr0 : pslverr3;
      acc_cycles = rdy ? n : -1;
      @(posedge pclk); #1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      logic        se;
      int          cyc;

      preset = 1'b1; psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pprot = '0; pwdata = '0; pstrb = '0;
      repeat (3) @(posedge pclk);
      #1 preset = 1'b0;

      // Reset state
      check("rst_prdata",  prdata0, 32'h0);
      check("rst_pready",  {31'd0, pready0}, 32'h0);
      check("rst_pslverr", {31'd0, pslverr0}, 32'h0);
      check("rst_err_cnt", {24'd0, err_cnt0}, 32'h0);
      check("rst_state",   {31'd0, dbg0}, 32'h0);

      // Zero-wait read of a cleared register
      apb_xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("rd0_cycles", cyc, 32'd1);
      check("rd0_data",   rd, 32'h0);
      check("rd0_slverr", {31'd0, se}, 32'h0);

      // Full-word write, then a single-byte overwrite, then read back
      apb_xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'b1111, 3'b000, rd, se, cyc);
      check("wr4_slverr", {31'd0, se}, 32'h0);
      apb_xfer(0, 1'b1, 32'h04, 32'h000000AA, 4'b0001, 3'b000, rd, se, cyc);
      apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("rd4_data", rd, 32'hDEADBEAA);
      check("rd4_prdata_clears", prdata0, 32'h0);

      // Zero strobes write nothing and raise no error
      apb_xfer(0, 1'b1, 32'h04, 32'h11111111, 4'b0000, 3'b000, rd, se, cyc);
      check("strb0_slverr", {31'd0, se}, 32'h0);
      apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'hF, 3'b000, rd, se, cyc);
      check("strb0_data", rd, 32'hDEADBEAA);

      // Three wait states: pready in access cycle 4
      apb_xfer(3, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("ws3_cycles", cyc, 32'd4);
      check("ws3_data",   rd, 32'h0);
      apb_xfer(3, 1'b1, 32'h14, 32'hCAFE0123, 4'hF, 3'b000, rd, se, cyc);
      apb_xfer(3, 1'b0, 32'h14, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("ws3_wr_rd", rd, 32'hCAFE0123);

      // Out-of-range write and misaligned read
      apb_xfer(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, 3'b000, rd, se, cyc);
      check("oor_slverr", {31'd0, se}, 32'h1);
      apb_xfer(0, 1'b0, 32'h06, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("mis_slverr", {31'd0, se}, 32'h1);
      check("mis_data",   rd, 32'h0);
      check("err_cnt_2",  {24'd0, err_cnt0}, 32'd2);
      apb_xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("err_noharm", rd, 32'hDEADBEAA);

      // Privileged region
      apb_xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 3'b000, rd, se, cyc);
      check("priv_user_slverr", {31'd0, se}, 32'h1);
      apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, se, cyc);
      check("priv_unchanged", rd, 32'h0);
      apb_xfer(0, 1'b1, 32'h40, 32'h12345678, 4'hF, 3'b001, rd, se, cyc);
      check("priv_ok_slverr", {31'd0, se}, 32'h0);
      apb_xfer(0, 1'b0, 32'h40, 32'h0, 4'h0, 3'b001, rd, se, cyc);
      check("priv_written", rd, 32'h12345678);
      check("err_cnt_3", {24'd0, err_cnt0}, 32'd3);

      // Master drops psel during the wait phase: the transfer is abandoned
      paddr = 32'h10; pwrite = 1'b1; pwdata = 32'h55555555; pstrb = 4'hF; pprot = 3'b000;
      psel3 = 1'b1; penable = 1'b0;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1 psel3 = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      check("abort_state", {31'd0, dbg3}, 32'h0);
      apb_xfer(3, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("abort_nowrite", rd, 32'h0);
      check("abort_err_cnt", {24'd0, err_cnt3}, 32'h0);

      // Reset in the middle of a waited write
      paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'hA5A5A5A5; pstrb = 4'hF; pprot = 3'b000;
      psel3 = 1'b1; penable = 1'b0;
      @(posedge pclk); #1 penable = 1'b1;
      @(posedge pclk); #1 preset = 1'b1;
      @(posedge pclk); #1;
      check("midrst_pready",  {31'd0, pready3}, 32'h0);
      check("midrst_pslverr", {31'd0, pslverr3}, 32'h0);
      check("midrst_prdata",  prdata3, 32'h0);
      check("midrst_state",   {31'd0, dbg3}, 32'h0);
      preset = 1'b0; psel3 = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      apb_xfer(3, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      check("midrst_reg3", rd, 32'h0);

      // Error counter saturation
      for (int i = 0; i < 254; i++) begin
         apb_xfer(0, 1'b0, 32'h01, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      end
      check("err_cnt_254", {24'd0, err_cnt0}, 32'd254);
      for (int i = 0; i < 46; i++) begin
         apb_xfer(0, 1'b0, 32'h01, 32'h0, 4'h0, 3'b000, rd, se, cyc);
      end
      check("err_cnt_sat", {24'd0, err_cnt0}, 32'd255);
      check("sat_last_slverr", {31'd0, se}, 32'h1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
